// File: rtl/pdm_mic_capture_if.sv
// Purpose : PCM sample stream between the PDM capture block and the next audio stage.
// Signals :
//   pcm_data  [OUT_W] decimated sample, driven by the producer
//   pcm_valid         pcm_data holds a sample not yet taken by the consumer
//   pcm_ready         consumer can take a sample
// Handshake: a sample moves on every clk posedge where pcm_valid & pcm_ready.
//   pcm_data is stable while pcm_valid is high until it is taken or overwritten.
//   pcm_ready has no effect while pcm_valid is low.
// Modports: master = producer (capture block), slave = consumer.
interface pdm_mic_capture_if #(
  parameter int OUT_W = 16
);
  logic [OUT_W-1:0] pcm_data;
  logic             pcm_valid;
  logic             pcm_ready;

  modport master (
    output pcm_data,
    output pcm_valid,
    input  pcm_ready
  );

  modport slave (
    input  pcm_data,
    input  pcm_valid,
    output pcm_ready
  );
endinterface

// File: rtl/pdm_mic_capture.sv
// Purpose : Captures a 1-bit PDM microphone stream clocked by the divided mic clock.
//   It detects the mic clock rising edges in the clk domain, samples the PDM bit on each edge,
//   counts ones over a window of DECIM bits (boxcar decimation), and offers each window
//   result as a PCM word on a valid/ready stream.
// Ports   :
//   clk         system clock, all logic on posedge
//   reset       asynchronous active-high reset; release is re-timed to clk internally
//   mic_clk_in  divided mic clock (asynchronous to clk)
//   mic_data    PDM data bit from the microphone (asynchronous to clk)
//   pcm         pdm_mic_capture_if.master: pcm_data / pcm_valid / pcm_ready
//   overrun     sticky flag: a sample not yet taken was overwritten (cleared only by reset)
//   active      low in reset, high in normal operation
// Build option:
//   PDM_SIGNED_OUT_EN defined   -> pcm_data = ones - DECIM/2, two's complement, sign-extended
//   PDM_SIGNED_OUT_EN undefined -> pcm_data = ones count, zero-extended
// Parameters: DECIM (even, >= 2) PDM bits per sample; OUT_W output width (> clog2(DECIM+1)).
module pdm_mic_capture #(
  parameter int DECIM = 64,
  parameter int OUT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mic_clk_in,
  input  logic              mic_data,
  pdm_mic_capture_if.master pcm,
  output logic              overrun,
  output logic              active
);
  localparam int CNT_W = $clog2(DECIM);
  localparam int ACC_W = $clog2(DECIM + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DECIM - 1);

  // Reset release re-timed to clk; run stays low for two cycles after reset drops.
  logic rst_q1;
  logic run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_q1 <= 1'b0;
      run    <= 1'b0;
    end else begin
      rst_q1 <= 1'b1;
      run    <= rst_q1;
    end
  end

  assign active = run;

  // Two-flop synchronisers for mic clock and data, plus the delayed clock for edge detection.
  logic ck_s1;
  logic ck_s2;
  logic ck_d;
  logic dt_s1;
  logic dt_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ck_s1 <= 1'b0;
      ck_s2 <= 1'b0;
      ck_d  <= 1'b0;
      dt_s1 <= 1'b0;
      dt_s2 <= 1'b0;
    end else begin
      ck_s1 <= mic_clk_in;
      ck_s2 <= ck_s1;
      ck_d  <= ck_s2;
      dt_s1 <= mic_data;
      dt_s2 <= dt_s1;
    end
  end

  // The synchronisers clear to 0, so a mic clock that is already high at reset release would
  // look like a rising edge. Edges are only accepted once the synchronised clock has been
  // seen low after release, so the first counted edge is a genuine 0->1 transition.
  logic armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (!run) begin
      armed <= 1'b0;
    end else if (!ck_s2) begin
      armed <= 1'b1;
    end
  end

  logic             mic_edge;
  logic             win_end;
  logic [CNT_W-1:0] bit_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] result;
  logic [OUT_W-1:0] pcm_word;

  assign mic_edge = armed & ck_s2 & ~ck_d;
  assign win_end  = mic_edge && (bit_cnt == LAST_BIT);
  // acc <= DECIM-1 before the last bit, so the sum fits in ACC_W bits.
  assign result   = acc + ACC_W'(dt_s2);

`ifdef PDM_SIGNED_OUT_EN
  logic signed [ACC_W:0] centred;

  always_comb begin
    centred  = $signed({1'b0, result}) - $signed((ACC_W + 1)'(DECIM / 2));
    pcm_word = OUT_W'(centred);
  end
`else
  always_comb begin
    pcm_word = OUT_W'(result);
  end
`endif

  // Window counter and ones accumulator; a stalled mic clock simply holds them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      acc     <= '0;
    end else if (!run) begin
      bit_cnt <= '0;
      acc     <= '0;
    end else if (mic_edge) begin
      if (win_end) begin
        bit_cnt <= '0;
        acc     <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        acc     <= result;
      end
    end
  end

  // Output register. A new result always loads; a transfer in the same cycle consumes the old
  // word, so pcm_valid stays high and no overrun is flagged. Loading over an untaken word
  // sets the sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcm.pcm_data  <= '0;
      pcm.pcm_valid <= 1'b0;
      overrun       <= 1'b0;
    end else if (!run) begin
      pcm.pcm_data  <= '0;
      pcm.pcm_valid <= 1'b0;
      overrun       <= 1'b0;
    end else if (win_end) begin
      pcm.pcm_data  <= pcm_word;
      pcm.pcm_valid <= 1'b1;
      if (pcm.pcm_valid && !pcm.pcm_ready) begin
        overrun <= 1'b1;
      end
    end else if (pcm.pcm_valid && pcm.pcm_ready) begin
      pcm.pcm_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pdm_mic_capture.sv
// Self-checking bench for pdm_mic_capture (DECIM=64, OUT_W=16, mic clock period 34 clk).
// The bench generates the mic clock and PDM bits itself; the reference model records every bit
// presented at a mic clock rise, counts ones per 64-bit window and queues the expected words.
module tb_pdm_mic_capture;
  localparam int DECIM = 64;
  localparam int OUT_W = 16;
  localparam int HALF  = 17;
  localparam int WIN_CYC = DECIM * 2 * HALF;

  localparam int M_ZERO = 0;
  localparam int M_ONE  = 1;
  localparam int M_ALT  = 2;
  localparam int M_RAND = 3;

  logic clk = 1'b0;
  logic reset;
  logic mic_clk_in;
  logic mic_data;
  logic overrun;
  logic active;

  pdm_mic_capture_if #(.OUT_W(OUT_W)) pcm_if ();

  pdm_mic_capture #(
    .DECIM(DECIM),
    .OUT_W(OUT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mic_clk_in(mic_clk_in),
    .mic_data  (mic_data),
    .pcm       (pcm_if.master),
    .overrun   (overrun),
    .active    (active)
  );

  // Clock / reset block: reset itself is driven from the main sequence.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state (written by the mic process only).
  int               mode    = M_ONE;
  bit               mic_en  = 1'b0;
  int               clr_req = 0;
  int               clr_seen = 0;
  int               m_acc   = 0;
  int               m_cnt   = 0;
  int               m_edges = 0;
  int               m_wins  = 0;
  logic [OUT_W-1:0] m_last  = '0;
  logic [OUT_W-1:0] exp_q[$];
  bit               alt_bit = 1'b0;

  // Scoreboard read side (monitor process only).
  bit mon_en = 1'b0;
  int rd_idx = 0;
  int n_xfer = 0;

  function automatic logic [OUT_W-1:0] exp_word(input int ones);
`ifdef PDM_SIGNED_OUT_EN
    return OUT_W'(ones - DECIM / 2);
`else
    return OUT_W'(ones);
`endif
  endfunction

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Mic clock and PDM source; signals change on negedge clk, away from the sampling edge.
  // New bits are presented on the mic clock fall, the model takes them on the rise.
  initial begin
    mic_clk_in = 1'b0;
    mic_data   = 1'b1;
    forever begin : mic_loop
      int ph;
      @(negedge clk);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        m_acc    = 0;
        m_cnt    = 0;
      end
      if (mic_en) begin
        ph = ph + 1;
        if (ph >= HALF) begin
          ph = 0;
          mic_clk_in = ~mic_clk_in;
          if (mic_clk_in) begin
            m_edges++;
            m_acc += int'(mic_data);
            m_cnt++;
            if (m_cnt == DECIM) begin
              m_last = exp_word(m_acc);
              exp_q.push_back(m_last);
              m_acc = 0;
              m_cnt = 0;
              m_wins++;
            end
          end else begin
            case (mode)
              M_ZERO:  mic_data = 1'b0;
              M_ONE:   mic_data = 1'b1;
              M_ALT:   begin alt_bit = ~alt_bit; mic_data = alt_bit; end
              default: mic_data = 1'($urandom_range(0, 1));
            endcase
          end
        end
      end
    end
  end

  // Scoreboard: every transfer must carry the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && pcm_if.pcm_valid && pcm_if.pcm_ready) begin
        n_xfer++;
        if (rd_idx < exp_q.size()) begin
          check("pcm_sample", pcm_if.pcm_data, exp_q[rd_idx]);
          rd_idx++;
        end else begin
          timeout_fail("pcm_unexpected_sample");
        end
      end
    end
  end

  // Driver tasks.
  task automatic run_windows(input int n, input bit rand_rdy);
    int w0;
    int budget;
    w0 = m_wins;
    budget = n * WIN_CYC + 200;
    while ((m_wins < w0 + n) && (budget > 0)) begin
      @(posedge clk);
      #1;
      if (rand_rdy) pcm_if.pcm_ready = 1'($urandom_range(0, 1));
      budget--;
    end
    if (m_wins < w0 + n) timeout_fail("window_wait");
  endtask

  task automatic wait_cnt(input int target);
    int budget;
    budget = WIN_CYC + 200;
    while ((m_cnt != target) && (budget > 0)) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (m_cnt != target) timeout_fail("bit_count_wait");
  endtask

  task automatic wait_rise();
    int e0;
    int budget;
    e0 = m_edges;
    budget = 4 * HALF;
    while ((m_edges == e0) && (budget > 0)) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (m_edges == e0) timeout_fail("mic_rise_wait");
  endtask

  task automatic wait_mic_low();
    int budget;
    budget = 4 * HALF;
    while ((mic_clk_in !== 1'b0) && (budget > 0)) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (mic_clk_in !== 1'b0) timeout_fail("mic_low_wait");
  endtask

  initial begin
    int e0;
    int budget;
    reset = 1'b1;
    pcm_if.pcm_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_pcm_data", pcm_if.pcm_data, '0);
    check("rst_pcm_valid", OUT_W'(pcm_if.pcm_valid), '0);
    check("rst_overrun", OUT_W'(overrun), '0);
    check("rst_active", OUT_W'(active), '0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("run_active", OUT_W'(active), OUT_W'(1));
    check("run_pcm_valid", OUT_W'(pcm_if.pcm_valid), '0);

    // Constant ones, constant zeros, alternating bits, then random bits with random ready.
    pcm_if.pcm_ready = 1'b1;
    mon_en = 1'b1;
    mic_en = 1'b1;
    run_windows(2, 1'b0);
    mode = M_ZERO;
    run_windows(2, 1'b0);
    mode = M_ALT;
    run_windows(2, 1'b0);
    check("alt_overrun", OUT_W'(overrun), '0);
    mode = M_RAND;
    run_windows(3, 1'b1);
    mode = M_ONE;
    pcm_if.pcm_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("drain_all_taken", OUT_W'(rd_idx), OUT_W'(exp_q.size()));
    check("drain_xfer_count", OUT_W'(n_xfer), OUT_W'(m_wins));
    check("drain_overrun", OUT_W'(overrun), '0);
    check("drain_pcm_valid", OUT_W'(pcm_if.pcm_valid), '0);

    // Consumer stalled across an all-ones window then an all-zeros window.
    mon_en = 1'b0;
    pcm_if.pcm_ready = 1'b0;
    run_windows(1, 1'b0);
    mode = M_ZERO;
    repeat (8) @(posedge clk);
    #1;
    check("stall1_pcm_data", pcm_if.pcm_data, m_last);
    check("stall1_pcm_valid", OUT_W'(pcm_if.pcm_valid), OUT_W'(1));
    check("stall1_overrun", OUT_W'(overrun), '0);
    run_windows(1, 1'b0);
    mode = M_ONE;
    repeat (8) @(posedge clk);
    #1;
    check("stall2_pcm_data", pcm_if.pcm_data, m_last);
    check("stall2_pcm_valid", OUT_W'(pcm_if.pcm_valid), OUT_W'(1));
    check("stall2_overrun", OUT_W'(overrun), OUT_W'(1));
    pcm_if.pcm_ready = 1'b1;
    @(posedge clk);
    #1;
    pcm_if.pcm_ready = 1'b0;
    check("take_pcm_valid", OUT_W'(pcm_if.pcm_valid), '0);
    check("take_overrun", OUT_W'(overrun), OUT_W'(1));

    // Reset pulsed 20 edges into an all-ones window (mic clock low at release).
    run_windows(1, 1'b0);
    wait_cnt(20);
    wait_mic_low();
    repeat (2) @(posedge clk);
    check("pre_rst_pcm_valid", OUT_W'(pcm_if.pcm_valid), OUT_W'(1));
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_pcm_data", pcm_if.pcm_data, '0);
    check("mid_rst_pcm_valid", OUT_W'(pcm_if.pcm_valid), '0);
    check("mid_rst_overrun", OUT_W'(overrun), '0);
    check("mid_rst_active", OUT_W'(active), '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    clr_req++;
    e0 = m_edges;
    budget = WIN_CYC + 200;
    while ((pcm_if.pcm_valid !== 1'b1) && (budget > 0)) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (pcm_if.pcm_valid !== 1'b1) timeout_fail("post_rst_valid_wait");
    check("post_rst_edges", OUT_W'(m_edges - e0), OUT_W'(DECIM));
    check("post_rst_pcm_data", pcm_if.pcm_data, m_last);
    check("post_rst_overrun", OUT_W'(overrun), '0);

    // Ready raised exactly for the load: the window-end rise is seen by the DUT on the second
    // clk posedge after it, and the result loads on the third.
    mode = M_ALT;
    wait_cnt(DECIM - 1);
    wait_rise();
    check("hold_pcm_data", pcm_if.pcm_data, exp_word(DECIM));
    @(posedge clk);
    @(posedge clk);
    #1;
    pcm_if.pcm_ready = 1'b1;
    @(posedge clk);
    #1;
    pcm_if.pcm_ready = 1'b0;
    check("same_cycle_pcm_valid", OUT_W'(pcm_if.pcm_valid), OUT_W'(1));
    check("same_cycle_pcm_data", pcm_if.pcm_data, m_last);
    check("same_cycle_overrun", OUT_W'(overrun), '0);
    pcm_if.pcm_ready = 1'b1;
    @(posedge clk);
    #1;
    pcm_if.pcm_ready = 1'b0;
    check("final_pcm_valid", OUT_W'(pcm_if.pcm_valid), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
